// File: rtl/sao_stat_ctrl.sv
// sao_stat_ctrl: per-CTB sequencer for one SAO statistics adder tree.
// The block latches the target category and the group count on ctb_start. It
// feeds groups to the tree and follows the tree's one-register latency. It adds
// the tree output s31 into a signed CTB sum and then offers that sum downstream.
//
// Handshake rule for both interfaces: a transfer happens in exactly the cycle
// where valid and ready are both high at the rising clock edge. A producer that
// raises valid keeps it, and its data, stable until that transfer.
// In this block:
//   - grp_valid/grp_ready: grp_ready is high for the whole of RUN.
//   - res_valid/res_ready: res_valid is high for the whole of OUT.
module sao_stat_ctrl #(
  parameter int N_BO_TYPE     = 5,
  parameter int DIFF_CLIP_BIT = 4,
  parameter int CNT_W         = 12,
  parameter int ACC_W         = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctb_start,
  input  logic [N_BO_TYPE-1:0]         cfg_cate,
  input  logic [CNT_W-1:0]             cfg_ngrp,
  input  logic                         grp_valid,
  output logic                         grp_ready,
  output logic                         stat_en,
  output logic                         stat_working,
  output logic [N_BO_TYPE-1:0]         stat_cate_target,
  input  logic [DIFF_CLIP_BIT+2:0]     stat_s31,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ACC_W-1:0]             res_sum,
  output logic [CNT_W-1:0]             res_ngrp,
  output logic                         busy,
  output logic                         err_start
);

  localparam int S_W = DIFF_CLIP_BIT + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 grp_ready_q, grp_ready_d;
  logic                 stat_working_q, stat_working_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;
  logic                 err_start_q, err_start_d;
  logic [N_BO_TYPE-1:0] cate_q, cate_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 acc_v_q, acc_v_d;
  logic [ACC_W-1:0]     res_sum_q, res_sum_d;
  logic [CNT_W-1:0]     res_ngrp_q, res_ngrp_d;

  logic [ACC_W-1:0]     s31_ext;
  logic [ACC_W-1:0]     acc_add;

  // The tree's en must go out in the same cycle as the group, so this output is combinational.
  assign stat_en = grp_valid & grp_ready_q;

  // The tree output belongs to the group accepted one cycle earlier. It is only added when acc_v_q marks it as fresh.
  always_comb begin
    s31_ext = {{(ACC_W - S_W){stat_s31[S_W-1]}}, stat_s31};
    acc_add = acc_v_q ? (acc_q + s31_ext) : acc_q;
  end

  // Compute the next state and all next-register values for the CTB sequence.
  always_comb begin
    state_d     = state_q;
    cate_d      = cate_q;
    remaining_d = remaining_q;
    count_d     = count_q + {{(CNT_W-1){1'b0}}, stat_en};
    acc_d       = acc_add;
    acc_v_d     = stat_en;
    res_sum_d   = res_sum_q;
    res_ngrp_d  = res_ngrp_q;
    err_start_d = ctb_start & (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (ctb_start) begin
          cate_d      = cfg_cate;
          remaining_d = cfg_ngrp;
          acc_d       = '0;
          count_d     = '0;
          if (cfg_ngrp == '0) begin
            state_d    = S_OUT;
            res_sum_d  = '0;
            res_ngrp_d = '0;
          end else begin
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stat_en) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Include the last group's s31, which is added in this same cycle.
        state_d    = S_OUT;
        res_sum_d  = acc_add;
        res_ngrp_d = count_q;
      end
      S_OUT: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    grp_ready_d    = (state_d == S_RUN);
    stat_working_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    res_valid_d    = (state_d == S_OUT);
    busy_d         = (state_d != S_IDLE);
  end

  // Register the state, the datapath and the control outputs. Reset clears everything, including a partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      grp_ready_q    <= 1'b0;
      stat_working_q <= 1'b0;
      res_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_start_q    <= 1'b0;
      cate_q         <= '0;
      remaining_q    <= '0;
      count_q        <= '0;
      acc_q          <= '0;
      acc_v_q        <= 1'b0;
      res_sum_q      <= '0;
      res_ngrp_q     <= '0;
    end else begin
      state_q        <= state_d;
      grp_ready_q    <= grp_ready_d;
      stat_working_q <= stat_working_d;
      res_valid_q    <= res_valid_d;
      busy_q         <= busy_d;
      err_start_q    <= err_start_d;
      cate_q         <= cate_d;
      remaining_q    <= remaining_d;
      count_q        <= count_d;
      acc_q          <= acc_d;
      acc_v_q        <= acc_v_d;
      res_sum_q      <= res_sum_d;
      res_ngrp_q     <= res_ngrp_d;
    end
  end

  assign grp_ready        = grp_ready_q;
  assign stat_working     = stat_working_q;
  assign stat_cate_target = cate_q;
  assign res_valid        = res_valid_q;
  assign res_sum          = res_sum_q;
  assign res_ngrp         = res_ngrp_q;
  assign busy             = busy_q;
  assign err_start        = err_start_q;

endmodule

// File: tb/tb_sao_stat_ctrl.sv
// tb_sao_stat_ctrl: directed and randomized CTB sequences for sao_stat_ctrl.
// A small behavioural tree model registers the group value when en is high and
// holds it otherwise. The expected CTB sum is the plain sum of the values offered.
module tb_sao_stat_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              ctb_start;
  logic [4:0]        cfg_cate;
  logic [11:0]       cfg_ngrp;
  logic              grp_valid;
  logic              grp_ready;
  logic              stat_en;
  logic              stat_working;
  logic [4:0]        stat_cate_target;
  logic [6:0]        stat_s31;
  logic              res_valid;
  logic              res_ready;
  logic [19:0]       res_sum;
  logic [11:0]       res_ngrp;
  logic              busy;
  logic              err_start;

  int checks = 0;
  int errors = 0;

  // Tree model: one register stage, holds stale data while en is low.
  logic [6:0] cur_s31 = '0;
  logic [6:0] tree_s31 = '0;
  assign stat_s31 = tree_s31;

  int     preset_q[$];
  bit     use_fixed = 1'b0;
  int     fixed_val = 0;
  int     pat_b[4] = '{0, 2, 0, 1};

  longint got_sum;
  int     got_n;

  sao_stat_ctrl #(
    .N_BO_TYPE(5), .DIFF_CLIP_BIT(4), .CNT_W(12), .ACC_W(20)
  ) dut (
    .clk(clk), .rst(rst), .ctb_start(ctb_start), .cfg_cate(cfg_cate),
    .cfg_ngrp(cfg_ngrp), .grp_valid(grp_valid), .grp_ready(grp_ready),
    .stat_en(stat_en), .stat_working(stat_working),
    .stat_cate_target(stat_cate_target), .stat_s31(stat_s31),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_ngrp(res_ngrp), .busy(busy), .err_start(err_start)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (stat_en === 1'b1) tree_s31 <= cur_s31;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int next_val();
    if (preset_q.size() > 0) return preset_q.pop_front();
    if (use_fixed) return fixed_val;
    return int'($urandom_range(0, 93)) - 48;
  endfunction

  // One complete CTB. bmode selects the bubbles: 0 none, 1 random, 2 pattern table.
  // poke pulses a start during OUT. poke_hs starts in the same cycle as the result handshake.
  task automatic run_ctb(input logic [4:0] cate, input int n, input int bmode,
                         input int hold, input bit poke, input bit poke_hs,
                         output longint sum_o, output int n_o);
    longint sum = 0;
    int b;
    int v;
    ctb_start = 1'b1; cfg_cate = cate; cfg_ngrp = n[11:0];
    tick();
    ctb_start = 1'b0;
    if (n == 0) begin
      grp_valid = 1'b1;
      #1;
      chk("zero_no_en", stat_en, 1'b0);
      chk("zero_no_ready", grp_ready, 1'b0);
      grp_valid = 1'b0;
    end else begin
      chk("run_busy", busy, 1'b1);
      chk("run_working", stat_working, 1'b1);
      chk("run_cate", stat_cate_target, cate);
      for (int i = 0; i < n; i++) begin
        b = (bmode == 0) ? 0 : (bmode == 1) ? int'($urandom_range(0, 2)) : pat_b[i];
        for (int k = 0; k < b; k++) begin
          grp_valid = 1'b0;
          cur_s31 = 7'($urandom);
          #1;
          chk("bubble_en", stat_en, 1'b0);
          tick();
        end
        v = next_val();
        grp_valid = 1'b1;
        cur_s31 = v[6:0];
        sum += v;
        #1;
        chk("accept_en", {grp_ready, stat_en}, 2'b11);
        tick();
      end
      grp_valid = 1'b0;
      chk("drain_ctrl", {grp_ready, stat_working, res_valid, stat_en}, 4'b0100);
      tick();
    end
    chk("out_valid", res_valid, 1'b1);
    chk("out_sum", $signed(res_sum), sum);
    chk("out_ngrp", res_ngrp, n);
    chk("out_ctrl", {busy, grp_ready, stat_working}, 3'b100);
    for (int k = 0; k < hold; k++) begin
      if (poke && k == 1) begin
        ctb_start = 1'b1; cfg_cate = ~cate; cfg_ngrp = 12'd7;
      end
      tick();
      ctb_start = 1'b0;
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_sum", $signed(res_sum), sum);
      chk("hold_ngrp", res_ngrp, n);
      if (poke && k == 1) begin
        chk("poke_err", err_start, 1'b1);
        chk("poke_cate", stat_cate_target, cate);
      end
      if (poke && k == 2) chk("poke_err_drop", err_start, 1'b0);
    end
    res_ready = 1'b1;
    ctb_start = poke_hs;
    tick();
    res_ready = 1'b0;
    ctb_start = 1'b0;
    chk("hs_valid_drop", res_valid, 1'b0);
    chk("hs_idle", busy, 1'b0);
    chk("hs_err", err_start, poke_hs);
    chk("idle_cate", stat_cate_target, cate);
    if (poke_hs) begin
      tick();
      chk("hs_start_ignored", {busy, err_start}, 2'b00);
    end
    sum_o = sum;
    n_o = n;
  endtask

  initial begin
    rst = 1'b1; ctb_start = 1'b0; cfg_cate = '0; cfg_ngrp = '0;
    grp_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ctrl", {grp_ready, stat_en, stat_working, res_valid, busy, err_start}, 6'b0);
    chk("rst_data", {stat_cate_target, res_sum, res_ngrp}, 37'b0);

    // Test 1: three groups, fixed values, no bubbles
    preset_q = '{5, -3, 10};
    run_ctb(5'd7, 3, 0, 0, 1'b0, 1'b0, got_sum, got_n);
    chk("t1_sum", got_sum, 12);

    // Test 2: valid pattern 1,0,0,1,1,0,1 with stale tree output during bubbles
    run_ctb(5'd3, 4, 2, 1, 1'b0, 1'b0, got_sum, got_n);

    // Test 3: empty CTB
    run_ctb(5'd12, 0, 0, 0, 1'b0, 1'b0, got_sum, got_n);

    // Test 4: result held for 5 cycles with a start during OUT, then start plus handshake
    run_ctb(5'd21, 2, 1, 5, 1'b1, 1'b1, got_sum, got_n);

    // Test 5: longest CTB with the most negative s31, no wrap
    use_fixed = 1'b1; fixed_val = -48;
    run_ctb(5'd31, 4095, 0, 0, 1'b0, 1'b0, got_sum, got_n);
    chk("t5_sum", got_sum, -196560);
    use_fixed = 1'b0;

    // Test 6: reset after 2 of 5 groups, then a fresh single-group CTB
    ctb_start = 1'b1; cfg_cate = 5'd9; cfg_ngrp = 12'd5;
    tick();
    ctb_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      grp_valid = 1'b1; cur_s31 = 7'($urandom_range(0, 40));
      tick();
    end
    grp_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_ctrl", {grp_ready, stat_en, stat_working, res_valid, busy, err_start}, 6'b0);
    chk("t6_rst_data", {stat_cate_target, res_sum, res_ngrp}, 37'b0);
    preset_q = '{9};
    run_ctb(5'd4, 1, 0, 0, 1'b0, 1'b0, got_sum, got_n);
    chk("t6_sum", got_sum, 9);

    // Randomized CTBs
    for (int r = 0; r < 8; r++) begin
      run_ctb(5'($urandom), int'($urandom_range(1, 20)), 1, int'($urandom_range(0, 3)),
              1'b0, 1'($urandom), got_sum, got_n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
